// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and constants for the matrix multiply engine
package matmul_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_CHECK,
        ST_LOADC,
        ST_MAC,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int HDR_ROWS_A = 0;
    localparam int HDR_COLS_A = 1;
    localparam int HDR_ROWS_B = 2;
    localparam int HDR_COLS_B = 3;
    localparam int A_BASE     = 4;

    localparam int MODE_SIGNED = 0;
    localparam int MODE_SAT    = 1;
    localparam int MODE_ACC    = 2;

endpackage

// File: rtl/matmul_engine_mac.sv
// rtl/matmul_engine_mac.sv - signed/unsigned multiply-accumulate with preload and saturating output
module mac_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 71
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  en,
    input  logic                  is_signed,
    input  logic                  saturate,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic signed [ACC_WIDTH-1:0] SMAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SMIN = ~SMAX;
    localparam logic signed [ACC_WIDTH-1:0] UMAX = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    logic signed [DATA_WIDTH:0]     a_x;
    logic signed [DATA_WIDTH:0]     b_x;
    logic signed [2*DATA_WIDTH+1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_x;
    logic signed [ACC_WIDTH-1:0]    load_x;
    logic signed [ACC_WIDTH-1:0]    acc;

    // one extra operand bit lets a single signed multiplier cover both modes
    assign a_x    = {is_signed & a[DATA_WIDTH-1], a};
    assign b_x    = {is_signed & b[DATA_WIDTH-1], b};
    assign prod   = a_x * b_x;
    assign prod_x = {{(ACC_WIDTH-2*DATA_WIDTH-2){prod[2*DATA_WIDTH+1]}}, prod};
    assign load_x = {{(ACC_WIDTH-DATA_WIDTH){is_signed & load_data[DATA_WIDTH-1]}}, load_data};

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_x;
        end else if (en) begin
            acc <= acc + prod_x;
        end
    end

    always_comb begin
        result = acc[DATA_WIDTH-1:0];
        if (saturate) begin
            if (is_signed) begin
                if (acc > SMAX)      result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
                else if (acc < SMIN) result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else if (acc > UMAX) begin
                result = '1;
            end
        end
    end

endmodule

// File: rtl/memory.sv
// rtl/memory.sv - dual-port word memory with registered reads on both ports
module memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wdata_a;
        if (we_b) mem[addr_b] <= wdata_b;
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - in-memory C = A*B (or C += A*B) engine with host port sharing
module matmul_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int MAX_LEN     = 100,
    parameter int MAX_LEN_LOG = 7,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+MAX_LEN_LOG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  host_we,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    import matmul_pkg::*;

    localparam int XW = 2*MAX_LEN_LOG + ADDR_WIDTH + 3;

    state_t                 state, state_nx;
    logic [MAX_LEN_LOG-1:0] m_q, k_q, n_q, i_q, j_q, kk_q;
    logic                   m_bad_q, k_bad_q, fault_q, done_q, error_q, host_own_q;
    logic [2:0]             mode_q;
    logic [ADDR_WIDTH-1:0]  b_base_q, c_base_q;

    logic [ADDR_WIDTH-1:0]  addr_a, addr_b;
    logic [DATA_WIDTH-1:0]  rdata_a, rdata_b, wdata_b, mac_result;
    logic                   we_b;

    logic [XW-1:0] b_base_x, c_base_x, c_end_x, a_addr_x, b_addr_x, c_addr_x;
    logic          fault, last_elem;

    function automatic logic dim_bad(input logic [DATA_WIDTH-1:0] d);
        return (d == '0) || (d > DATA_WIDTH'(MAX_LEN));
    endfunction

    // in CHECK, rdata_a/rdata_b carry rows_b and cols_b straight from memory
    assign b_base_x = XW'(A_BASE) + XW'(m_q) * XW'(k_q);
    assign c_base_x = b_base_x + XW'(k_q) * XW'(MAX_LEN_LOG'(rdata_b));
    assign c_end_x  = c_base_x + XW'(m_q) * XW'(MAX_LEN_LOG'(rdata_b));
    assign fault    = m_bad_q | k_bad_q | dim_bad(rdata_a) | dim_bad(rdata_b)
                    | (rdata_a != DATA_WIDTH'(k_q))
                    | (c_end_x > (XW'(1) << ADDR_WIDTH));

    assign a_addr_x  = XW'(A_BASE) + XW'(i_q) * XW'(k_q) + XW'(kk_q);
    assign b_addr_x  = XW'(b_base_q) + XW'(kk_q) * XW'(n_q) + XW'(j_q);
    assign c_addr_x  = XW'(c_base_q) + XW'(i_q) * XW'(n_q) + XW'(j_q);
    assign last_elem = (i_q == m_q - 1'b1) && (j_q == n_q - 1'b1);

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_HDR0;
            ST_HDR0:  state_nx = ST_HDR1;
            ST_HDR1:  state_nx = ST_CHECK;
            ST_CHECK: begin
                if (fault)                 state_nx = ST_DONE;
                else if (mode_q[MODE_ACC]) state_nx = ST_LOADC;
                else                       state_nx = ST_MAC;
            end
            ST_LOADC: state_nx = ST_MAC;
            ST_MAC:   if (kk_q == k_q - 1'b1) state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_WRITE;
            ST_WRITE: begin
                if (last_elem)             state_nx = ST_DONE;
                else if (mode_q[MODE_ACC]) state_nx = ST_LOADC;
                else                       state_nx = ST_MAC;
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q     <= '0;
            m_q        <= '0;
            k_q        <= '0;
            n_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            kk_q       <= '0;
            m_bad_q    <= 1'b0;
            k_bad_q    <= 1'b0;
            fault_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            host_own_q <= 1'b0;
            b_base_q   <= '0;
            c_base_q   <= '0;
        end else begin
            done_q     <= (state == ST_DONE);
            host_own_q <= (state == ST_IDLE);
            case (state)
                ST_IDLE: if (start) begin
                    mode_q  <= mode;
                    error_q <= 1'b0;
                    fault_q <= 1'b0;
                end
                ST_HDR1: begin
                    m_q     <= MAX_LEN_LOG'(rdata_a);
                    k_q     <= MAX_LEN_LOG'(rdata_b);
                    m_bad_q <= dim_bad(rdata_a);
                    k_bad_q <= dim_bad(rdata_b);
                end
                ST_CHECK: begin
                    n_q      <= MAX_LEN_LOG'(rdata_b);
                    b_base_q <= ADDR_WIDTH'(b_base_x);
                    c_base_q <= ADDR_WIDTH'(c_base_x);
                    fault_q  <= fault;
                    i_q      <= '0;
                    j_q      <= '0;
                    kk_q     <= '0;
                end
                ST_MAC: kk_q <= (kk_q == k_q - 1'b1) ? '0 : kk_q + 1'b1;
                ST_WRITE: begin
                    if (j_q == n_q - 1'b1) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                ST_DONE: error_q <= fault_q;
                default: ;
            endcase
        end
    end

    // host owns port B only in IDLE; writes are also blocked while reset is asserted
    always_comb begin
        addr_a  = '0;
        addr_b  = (state == ST_IDLE) ? host_addr : '0;
        wdata_b = (state == ST_IDLE) ? host_wdata : '0;
        we_b    = (state == ST_IDLE) && host_we && reset;
        case (state)
            ST_HDR0: begin
                addr_a = ADDR_WIDTH'(HDR_ROWS_A);
                addr_b = ADDR_WIDTH'(HDR_COLS_A);
            end
            ST_HDR1: begin
                addr_a = ADDR_WIDTH'(HDR_ROWS_B);
                addr_b = ADDR_WIDTH'(HDR_COLS_B);
            end
            ST_LOADC: addr_b = ADDR_WIDTH'(c_addr_x);
            ST_MAC: begin
                addr_a = ADDR_WIDTH'(a_addr_x);
                addr_b = ADDR_WIDTH'(b_addr_x);
            end
            ST_WRITE: begin
                addr_b  = ADDR_WIDTH'(c_addr_x);
                wdata_b = mac_result;
                we_b    = reset;
            end
            default: ;
        endcase
    end

    memory #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_memory (
        .clk     (clk),
        .addr_a  (addr_a),
        .wdata_a ('0),
        .we_a    (1'b0),
        .rdata_a (rdata_a),
        .addr_b  (addr_b),
        .wdata_b (wdata_b),
        .we_b    (we_b),
        .rdata_b (rdata_b)
    );

    // the C preload arrives in the first MAC cycle, before any product is valid
    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .clear     ((state == ST_CHECK) || (state == ST_WRITE)),
        .load      ((state == ST_MAC) && (kk_q == '0) && mode_q[MODE_ACC]),
        .en        (((state == ST_MAC) && (kk_q != '0)) || (state == ST_DRAIN)),
        .is_signed (mode_q[MODE_SIGNED]),
        .saturate  (mode_q[MODE_SAT]),
        .a         (rdata_a),
        .b         (rdata_b),
        .load_data (rdata_b),
        .result    (mac_result)
    );

    assign busy       = (state != ST_IDLE) || done_q;
    assign done       = done_q;
    assign error      = error_q;
    assign host_rdata = (host_own_q && !busy) ? rdata_b : '0;

endmodule

// File: tb/tb_matmul_engine.sv
// tb/tb_matmul_engine.sv - directed self-checking bench for matmul_engine
module tb_matmul_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mode;
    logic [11:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_we;
    logic [31:0] host_rdata;
    logic        busy;
    logic        done;
    logic        error;

    int vectors;
    int miscompares;

    logic [31:0] a_vals [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    logic [31:0] b_vals [6] = '{32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12};
    logic [31:0] rd;

    matmul_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_we    (host_we),
        .host_rdata (host_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        host_addr  = 12'(addr);
        host_wdata = data;
        host_we    = 1'b1;
        tick();
        host_we    = 1'b0;
    endtask

    task automatic rdw(input int addr, output logic [31:0] data);
        host_addr = 12'(addr);
        host_we   = 1'b0;
        tick();
        data = host_rdata;
    endtask

    task automatic read_check(input string tag, input int addr, input logic [31:0] exp);
        logic [31:0] d;
        rdw(addr, d);
        check(tag, 64'(d), 64'(exp));
    endtask

    task automatic load_2x3x2();
        wr(0, 32'd2); wr(1, 32'd3); wr(2, 32'd3); wr(3, 32'd2);
        for (int i = 0; i < 6; i++) wr(4 + i, a_vals[i]);
        for (int i = 0; i < 6; i++) wr(10 + i, b_vals[i]);
    endtask

    task automatic run(input logic [2:0] md, input int exp_t, input logic poke, input logic exp_err);
        int n;
        n     = 0;
        mode  = md;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        while (!done && n < 300) begin
            if (poke && n >= 1 && n < 4) begin
                host_addr  = 12'd4;
                host_wdata = 32'd99;
                host_we    = 1'b1;
            end else begin
                host_we = 1'b0;
            end
            tick();
            n++;
            if (poke && n >= 2 && n <= 4) check("rdata_zero_busy", 64'(host_rdata), 64'(0));
        end
        host_we = 1'b0;
        check("done_latency", 64'(n), 64'(exp_t));
        check("error_at_done", 64'(error), 64'(exp_err));
        tick();
        check("done_falls", 64'(done), 64'(0));
        check("busy_falls", 64'(busy), 64'(0));
    endtask

    task automatic run_1x1(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string tag);
        wr(0, 32'd1); wr(1, 32'd1); wr(2, 32'd1); wr(3, 32'd1);
        wr(4, a); wr(5, b); wr(6, 32'h5555_5555);
        run(md, 7, 1'b0, 1'b0);
        read_check(tag, 6, exp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start       = 1'b0;
        mode        = 3'd0;
        host_addr   = '0;
        host_wdata  = '0;
        host_we     = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_rdata", 64'(host_rdata), 64'(0));
        reset = 1'b1;
        tick();

        // unsigned 2x3x2
        load_2x3x2();
        for (int i = 0; i < 4; i++) wr(16 + i, 32'd0);
        run(3'b000, 24, 1'b0, 1'b0);
        read_check("c00", 16, 32'd58);
        read_check("c01", 17, 32'd64);
        read_check("c10", 18, 32'd139);
        read_check("c11", 19, 32'd154);

        // header mismatch rows_b != cols_a
        wr(2, 32'd2);
        run(3'b000, 4, 1'b0, 1'b1);
        check("error_held", 64'(error), 64'(1));
        read_check("fault_c00", 16, 32'd58);
        read_check("fault_c11", 19, 32'd154);
        wr(2, 32'd3);

        // accumulate, with a dropped host write to A[0][0] mid-run
        for (int i = 0; i < 4; i++) wr(16 + i, 32'd1);
        run(3'b100, 28, 1'b1, 1'b0);
        read_check("acc_c00", 16, 32'd59);
        read_check("acc_c01", 17, 32'd65);
        read_check("acc_c10", 18, 32'd140);
        read_check("acc_c11", 19, 32'd155);
        read_check("a00_kept", 4, 32'd1);

        // 1x1x1 arithmetic corners
        run_1x1(3'b011, 32'h7FFF_FFFF, 32'd2, 32'h7FFF_FFFF, "sat_pos");
        run_1x1(3'b001, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, "wrap_pos");
        run_1x1(3'b001, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, "signed_neg");
        run_1x1(3'b011, 32'h8000_0000, 32'd2, 32'h8000_0000, "sat_neg");
        run_1x1(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "sat_unsigned");
        run_1x1(3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "unsigned_wrap");

        // reset during MAC of element (0,1)
        load_2x3x2();
        for (int i = 0; i < 4; i++) wr(16 + i, 32'hAAAA_AAAA);
        mode  = 3'b000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b0;
        tick();
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_error", 64'(error), 64'(0));
        check("midrst_rdata", 64'(host_rdata), 64'(0));
        reset = 1'b1;
        read_check("midrst_c00", 16, 32'd58);
        read_check("midrst_c01", 17, 32'hAAAA_AAAA);
        read_check("midrst_c10", 18, 32'hAAAA_AAAA);
        run(3'b000, 24, 1'b0, 1'b0);
        read_check("rerun_c01", 17, 32'd64);
        read_check("rerun_c11", 19, 32'd154);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
